// File: rtl/svm_pkg.sv
// Shared types and width helpers for the linear-kernel SVM decision stage.
package svm_pkg;

  // state | meaning
  // IDLE  | waiting for decision_funct_en with memory ready
  // FETCH | issuing one pixel read per unstalled cycle for the current SV
  // DRAIN | capturing the product of the last read of this SV
  // SCALE | sum += alpha * dot, then next SV or on to BIAS
  // BIAS  | sum += bias, result registered
  // DONE  | done pulse, result valid
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_SCALE,
    ST_BIAS,
    ST_DONE
  } state_e;

  // Address and index widths never drop below one bit.
  function automatic int clog2_min1(input int v);
    if (v <= 2) return 1;
    return $clog2(v);
  endfunction

  // Unsigned dot-product width: N products of two pixels cannot overflow it.
  function automatic int dot_width(input int xlen, input int n);
    return 2 * xlen + clog2_min1(n);
  endfunction

  localparam int DEF_XLEN_PIXEL    = 8;
  localparam int DEF_NUM_OF_PIXELS = 784;
  localparam int DEF_NUM_OF_SV     = 10;
  localparam int DEF_ALPHA_W       = 16;
  localparam int DEF_ACC_W         = 48;
  localparam int DEF_DOT_W         = dot_width(DEF_XLEN_PIXEL, DEF_NUM_OF_PIXELS);
  localparam int DEF_X_AW          = clog2_min1(DEF_NUM_OF_PIXELS);
  localparam int DEF_SV_AW         = clog2_min1(DEF_NUM_OF_PIXELS * DEF_NUM_OF_SV);

endpackage

// File: rtl/svm_dot_mac.sv
// Unsigned pixel multiply-accumulate for one support-vector dot product.
// Read data arrives one cycle after the read strobe, so the strobe is delayed
// by one flop to qualify the capture.
module svm_dot_mac
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = DEF_XLEN_PIXEL,
  parameter int DOT_W      = DEF_DOT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  rd_en_i,
  input  logic [XLEN_PIXEL-1:0] x_pixel_i,
  input  logic [XLEN_PIXEL-1:0] sv_pixel_i,
  output logic [DOT_W-1:0]      dot_o
);

  localparam int PROD_W = 2 * XLEN_PIXEL;

  logic             cap_q;
  logic [DOT_W-1:0] dot_q;
  logic [PROD_W-1:0] prod;
  logic [DOT_W-1:0]  prod_ext;

  // Full-width unsigned pixel product, zero-extended to the accumulator.
  always_comb begin
    prod     = {{XLEN_PIXEL{1'b0}}, x_pixel_i} * {{XLEN_PIXEL{1'b0}}, sv_pixel_i};
    prod_ext = {{(DOT_W - PROD_W){1'b0}}, prod};
  end

  // Capture-valid flop and accumulator; clear wins over a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= 1'b0;
      dot_q <= '0;
    end else begin
      cap_q <= rd_en_i;
      if (clear_i) begin
        dot_q <= '0;
      end else if (cap_q) begin
        dot_q <= dot_q + prod_ext;
      end
    end
  end

  assign dot_o = dot_q;

endmodule

// File: rtl/svm_decision_funct.sv
// Linear-kernel SVM decision value: sum_k alpha_k * <x, sv_k> + bias.
// Reads one pixel pair per unstalled FETCH cycle, scales each finished dot
// product by its signed alpha and emits score plus a sign decision.
module svm_decision_funct
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
  parameter int ALPHA_W       = DEF_ALPHA_W,
  parameter int ACC_W         = DEF_ACC_W
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             decision_funct_en,
  input  logic                                             stall_MEM,
  input  logic [XLEN_PIXEL-1:0]                            x_pixel,
  input  logic [XLEN_PIXEL-1:0]                            sv_pixel,
  input  logic signed [ALPHA_W-1:0]                        alpha_in,
  input  logic signed [ALPHA_W-1:0]                        bias,
  output logic                                             rd_en,
  output logic [clog2_min1(NUM_OF_PIXELS)-1:0]             x_rd_addr,
  output logic [clog2_min1(NUM_OF_PIXELS*NUM_OF_SV)-1:0]   sv_rd_addr,
  output logic [clog2_min1(NUM_OF_SV)-1:0]                 sv_idx,
  output logic                                             busy,
  output logic                                             done,
  output logic signed [ACC_W-1:0]                          score,
  output logic                                             decision
);

  localparam int X_AW   = clog2_min1(NUM_OF_PIXELS);
  localparam int SV_AW  = clog2_min1(NUM_OF_PIXELS * NUM_OF_SV);
  localparam int IDX_W  = clog2_min1(NUM_OF_SV);
  localparam int DOT_W  = dot_width(XLEN_PIXEL, NUM_OF_PIXELS);
  localparam int PROD_W = ALPHA_W + DOT_W + 1;

  localparam logic [X_AW-1:0]  PIX_LAST = X_AW'(NUM_OF_PIXELS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OF_SV - 1);

  state_e                   state_q;
  logic [X_AW-1:0]          pix_q;
  logic [SV_AW-1:0]         sv_addr_q;
  logic [IDX_W-1:0]         sv_idx_q;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  score_q;
  logic                     decision_q;
  logic                     done_q;
  logic                     busy_q;

  logic                     start;
  logic                     mac_clear;
  logic [DOT_W-1:0]         dot;
  logic signed [PROD_W-1:0] alpha_x;
  logic signed [PROD_W-1:0] dot_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  scaled_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum_bias_d;

  // Start qualification, read strobe and alpha/bias scaling arithmetic.
  always_comb begin
    start      = (state_q == ST_IDLE) && decision_funct_en && !stall_MEM;
    rd_en      = (state_q == ST_FETCH) && !stall_MEM;
    mac_clear  = start || (state_q == ST_SCALE);
    alpha_x    = {{(PROD_W - ALPHA_W){alpha_in[ALPHA_W-1]}}, alpha_in};
    dot_x      = {{(PROD_W - DOT_W){1'b0}}, dot};
    prod       = alpha_x * dot_x;
    scaled_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext   = {{(ACC_W - ALPHA_W){bias[ALPHA_W-1]}}, bias};
    sum_bias_d = sum_q + bias_ext;
  end

  svm_dot_mac #(
    .XLEN_PIXEL (XLEN_PIXEL),
    .DOT_W      (DOT_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (mac_clear),
    .rd_en_i    (rd_en),
    .x_pixel_i  (x_pixel),
    .sv_pixel_i (sv_pixel),
    .dot_o      (dot)
  );

  // Sequencer: address counters, SV index, alpha/bias accumulation, outputs.
  // The result is registered on the BIAS->DONE edge so score is already
  // valid in the cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      sv_addr_q  <= '0;
      sv_idx_q   <= '0;
      sum_q      <= '0;
      score_q    <= '0;
      decision_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sum_q     <= '0;
            pix_q     <= '0;
            sv_addr_q <= '0;
            sv_idx_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!stall_MEM) begin
            if (pix_q == PIX_LAST) begin
              state_q <= ST_DRAIN;
            end else begin
              pix_q     <= pix_q + X_AW'(1);
              sv_addr_q <= sv_addr_q + SV_AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_SCALE;
        end
        ST_SCALE: begin
          sum_q <= sum_q + scaled_ext;
          if (sv_idx_q == IDX_LAST) begin
            state_q <= ST_BIAS;
          end else begin
            sv_idx_q  <= sv_idx_q + IDX_W'(1);
            pix_q     <= '0;
            sv_addr_q <= sv_addr_q + SV_AW'(1);
            state_q   <= ST_FETCH;
          end
        end
        ST_BIAS: begin
          sum_q      <= sum_bias_d;
          score_q    <= sum_bias_d;
          decision_q <= ~sum_bias_d[ACC_W-1];
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign x_rd_addr  = pix_q;
  assign sv_rd_addr = sv_addr_q;
  assign sv_idx     = sv_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign score      = score_q;
  assign decision   = decision_q;

endmodule
